// File: rtl/router_input_port_if.sv
// Flit and route-request bundle between a router input port and its environment.
// master = upstream/arbiter side, slave = the input port itself.
interface router_input_port_if #(
  parameter int FlitWidth = 34
);
  logic [FlitWidth-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [4:0]           request;
  logic [4:0]           grant;
  logic [4:0]           out_ready;
  logic [FlitWidth-1:0] data_out;
  logic [4:0]           data_out_valid;
  logic                 forwarding_head;
  logic                 forwarding_tail;

  modport master (
    output data_in, data_in_valid, grant, out_ready,
    input  data_in_ready, request, data_out, data_out_valid,
           forwarding_head, forwarding_tail
  );

  modport slave (
    input  data_in, data_in_valid, grant, out_ready,
    output data_in_ready, request, data_out, data_out_valid,
           forwarding_head, forwarding_tail
  );
endinterface

// File: rtl/router_input_port.sv
// NoC router input port: flit FIFO, XY route computation on head flits and
// wormhole forwarding toward the five output-port arbiters.
module router_input_port #(
  parameter int FlitWidth  = 34,
  parameter int Depth      = 4,
  parameter int CoordWidth = 3,
  parameter int DestYLsb   = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CoordWidth-1:0] position_x,
  input  logic [CoordWidth-1:0] position_y,
  router_input_port_if.slave    ifc,
  output logic                  proto_err
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = PtrWidth + 1;
  localparam int DestXLsb = DestYLsb - CoordWidth;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [4:0] PORT_N = 5'b00001;
  localparam logic [4:0] PORT_S = 5'b00010;
  localparam logic [4:0] PORT_W = 5'b00100;
  localparam logic [4:0] PORT_E = 5'b01000;
  localparam logic [4:0] PORT_L = 5'b10000;

  logic [FlitWidth-1:0]  mem_q [Depth];
  logic [PtrWidth-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrWidth-1:0]   rdPtr_q, rdPtr_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic [4:0]            route_q, route_d;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  fwd;
  logic                  drop;
  logic                  headBit;
  logic                  tailBit;
  logic [FlitWidth-1:0]  headFlit;
  logic [CoordWidth-1:0] destX;
  logic [CoordWidth-1:0] destY;
  logic [4:0]            routeComb;
  logic [4:0]            routeSel;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntWidth'(Depth));

  always_comb begin
    headFlit = mem_q[rdPtr_q];
    headBit  = headFlit[FlitWidth-1];
    tailBit  = headFlit[FlitWidth-2];
    destY    = headFlit[DestYLsb +: CoordWidth];
    destX    = headFlit[DestXLsb +: CoordWidth];

    // XY routing: resolve X first, then Y, else deliver locally
    if (destX > position_x) begin
      routeComb = PORT_E;
    end else if (destX < position_x) begin
      routeComb = PORT_W;
    end else if (destY > position_y) begin
      routeComb = PORT_S;
    end else if (destY < position_y) begin
      routeComb = PORT_N;
    end else begin
      routeComb = PORT_L;
    end

    // Mid-packet the locked route is held even across FIFO bubbles
    if (state_q == IDLE) begin
      routeSel = (!empty && headBit) ? routeComb : 5'b00000;
    end else begin
      routeSel = route_q;
    end

    fwd  = !empty && (|(routeSel & ifc.grant & ifc.out_ready));
    drop = (state_q == IDLE) && !empty && !headBit;
    push = ifc.data_in_valid && !full;
    pop  = fwd || drop;
  end

  assign ifc.request         = routeSel;
  assign ifc.data_out        = headFlit;
  assign ifc.data_out_valid  = fwd ? routeSel : 5'b00000;
  assign ifc.forwarding_head = fwd && (state_q == IDLE);
  assign ifc.forwarding_tail = fwd && tailBit;
  assign ifc.data_in_ready   = rst && !full;
  assign proto_err           = drop;

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PtrWidth'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PtrWidth'(1) : rdPtr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    route_d = route_q;
    if (fwd) begin
      if (state_q == IDLE) begin
        if (!tailBit) begin
          state_d = ACTIVE;
          route_d = routeComb;
        end
      end else if (tailBit) begin
        state_d = IDLE;
        route_d = 5'b00000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      state_q <= IDLE;
      route_q <= 5'b00000;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= ifc.data_in;
    end
  end

`ifndef SYNTHESIS
  requestOneHot: assert property (@(posedge clk) disable iff (!rst) $onehot0(ifc.request));
  validOneHot:   assert property (@(posedge clk) disable iff (!rst) $onehot0(ifc.data_out_valid));
  noPopEmpty:    assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
  noPushFull:    assert property (@(posedge clk) disable iff (!rst) !(push && full));
`endif

endmodule

// File: tb/tb_router_input_port.sv
// Randomised bench for router_input_port: a stream-level packet model fills a
// scoreboard at push time; an independent monitor checks every cycle.
module tb_router_input_port;

  localparam int FlitWidth  = 34;
  localparam int Depth      = 4;
  localparam int CoordWidth = 3;
  localparam int DestYLsb   = 26;

  typedef struct {
    logic [FlitWidth-1:0] data;
    bit                   drop;
    logic [4:0]           route;
    bit                   fh;
    bit                   ft;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [CoordWidth-1:0] posX;
  logic [CoordWidth-1:0] posY;
  logic                  protoErr;

  exp_t       sb[$];
  bit         inPkt;
  logic [4:0] inRoute;
  bit         outPkt;
  logic [4:0] outRoute;
  bit         monEn;
  int         nChecks;
  int         nFails;

  router_input_port_if #(.FlitWidth(FlitWidth)) ifc ();

  router_input_port #(
    .FlitWidth(FlitWidth), .Depth(Depth), .CoordWidth(CoordWidth), .DestYLsb(DestYLsb)
  ) dut (
    .clk(clk), .rst(rst), .position_x(posX), .position_y(posY),
    .ifc(ifc), .proto_err(protoErr)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] refRoute(input logic [2:0] dx, input logic [2:0] dy);
    if (dx > posX)      return 5'b01000;
    else if (dx < posX) return 5'b00100;
    else if (dy > posY) return 5'b00010;
    else if (dy < posY) return 5'b00001;
    else                return 5'b10000;
  endfunction

  function automatic logic [FlitWidth-1:0] mkFlit(input bit h, input bit t,
                                                  input logic [2:0] dx, input logic [2:0] dy);
    logic [FlitWidth-1:0] f;
    f = {2'b00, 32'($urandom)};
    f[FlitWidth-1] = h;
    f[FlitWidth-2] = t;
    f[DestYLsb +: CoordWidth] = dy;
    f[DestYLsb-CoordWidth +: CoordWidth] = dx;
    return f;
  endfunction

  // Packet-level model: classify each accepted flit by where it sits in the stream
  task automatic modelPush(input logic [FlitWidth-1:0] f);
    exp_t e;
    e.data = f;
    e.drop = 1'b0;
    e.fh   = 1'b0;
    e.ft   = f[FlitWidth-2];
    e.route = inRoute;
    if (!inPkt) begin
      if (f[FlitWidth-1]) begin
        e.route = refRoute(f[DestYLsb-CoordWidth +: CoordWidth], f[DestYLsb +: CoordWidth]);
        e.fh    = 1'b1;
        inPkt   = !f[FlitWidth-2];
        inRoute = e.route;
      end else begin
        e.drop  = 1'b1;
        e.route = 5'b00000;
        e.ft    = 1'b0;
      end
    end else if (f[FlitWidth-2]) begin
      inPkt = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit v, input logic [FlitWidth-1:0] d, input logic [4:0] g,
                               input bit follow, input logic [4:0] ordy);
    bit acc;
    @(negedge clk);
    ifc.data_in_valid = v;
    ifc.data_in       = d;
    ifc.out_ready     = ordy;
    ifc.grant         = follow ? ifc.request : g;
    acc = v && (sb.size() < Depth);
    @(posedge clk);
    if (acc) modelPush(d);
  endtask

  task automatic checkOutput();
    logic [4:0] expReq;
    logic [4:0] expDov;
    bit expFh, expFt, expErr, popIt;
    exp_t e;
    compare("data_in_ready", 64'(ifc.data_in_ready), 64'(sb.size() < Depth));
    expReq = outPkt ? outRoute : 5'b00000;
    expDov = 5'b00000;
    expFh = 1'b0; expFt = 1'b0; expErr = 1'b0; popIt = 1'b0;
    if (sb.size() > 0) begin
      e = sb[0];
      if (e.drop) begin
        expReq = 5'b00000;
        expErr = 1'b1;
        popIt  = 1'b1;
      end else begin
        expReq = e.route;
        if ((e.route & ifc.grant & ifc.out_ready) != 5'b00000) begin
          expDov = e.route;
          expFh  = e.fh;
          expFt  = e.ft;
          popIt  = 1'b1;
        end
      end
    end
    compare("request", 64'(ifc.request), 64'(expReq));
    compare("data_out_valid", 64'(ifc.data_out_valid), 64'(expDov));
    compare("forwarding_head", 64'(ifc.forwarding_head), 64'(expFh));
    compare("forwarding_tail", 64'(ifc.forwarding_tail), 64'(expFt));
    compare("proto_err", 64'(protoErr), 64'(expErr));
    if (popIt && !e.drop) compare("data_out", 64'(ifc.data_out), 64'(e.data));
    if (popIt) begin
      void'(sb.pop_front());
      if (!e.drop) begin
        if (e.fh && !e.ft) begin
          outPkt   = 1'b1;
          outRoute = e.route;
        end else if (e.ft) begin
          outPkt = 1'b0;
        end
      end
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (monEn) checkOutput();
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] ordy;
    logic [4:0] g;
    bit follow;
    int r;
    nChecks = 0; nFails = 0;
    inPkt = 1'b0; inRoute = 5'b00000; outPkt = 1'b0; outRoute = 5'b00000;
    monEn = 1'b0;
    posX = 3'd1; posY = 3'd1;
    ifc.data_in_valid = 1'b0; ifc.data_in = '0; ifc.grant = 5'b00000; ifc.out_ready = 5'b00000;

    #1;
    compare("reset request", 64'(ifc.request), 64'(0));
    compare("reset data_in_ready", 64'(ifc.data_in_ready), 64'(0));
    compare("reset data_out_valid", 64'(ifc.data_out_valid), 64'(0));
    compare("reset forwarding_head", 64'(ifc.forwarding_head), 64'(0));
    compare("reset forwarding_tail", 64'(ifc.forwarding_tail), 64'(0));
    compare("reset proto_err", 64'(protoErr), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    monEn = 1'b1;
    #1;
    compare("ready after release", 64'(ifc.data_in_ready), 64'(1));

    // Single-flit packet east
    applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 3'd3, 3'd1), 5'b01000, 1'b0, 5'h1f);
    repeat (3) applyStimulus(1'b0, '0, 5'b01000, 1'b0, 5'h1f);

    // Four-flit packet north with a two-cycle input bubble after flit 1
    applyStimulus(1'b1, mkFlit(1'b1, 1'b0, 3'd1, 3'd0), 5'b00001, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 3'd1, 3'd0), 5'b00001, 1'b0, 5'h1f);
    repeat (2) applyStimulus(1'b0, '0, 5'b00001, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b1, 1'b0, 3'd5, 3'd5), 5'b00001, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b0, 1'b1, 3'd1, 3'd0), 5'b00001, 1'b0, 5'h1f);
    repeat (3) applyStimulus(1'b0, '0, 5'b00001, 1'b0, 5'h1f);

    // Local packet stalled by out_ready[4] for three cycles
    applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 3'd1, 3'd1), 5'b10000, 1'b0, 5'h0f);
    repeat (3) applyStimulus(1'b0, '0, 5'b10000, 1'b0, 5'h0f);
    repeat (2) applyStimulus(1'b0, '0, 5'b10000, 1'b0, 5'h1f);

    // Fill the FIFO with no grant, then offer a fifth flit
    applyStimulus(1'b1, mkFlit(1'b1, 1'b0, 3'd2, 3'd1), 5'b00000, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 3'd2, 3'd1), 5'b00000, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 3'd2, 3'd1), 5'b00000, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b0, 1'b1, 3'd2, 3'd1), 5'b00000, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 3'd0, 3'd0), 5'b00000, 1'b0, 5'h1f);
    applyStimulus(1'b0, '0, 5'b00000, 1'b1, 5'h1f);
    applyStimulus(1'b0, '0, 5'b00000, 1'b0, 5'h1f);
    repeat (5) applyStimulus(1'b0, '0, 5'b00000, 1'b1, 5'h1f);

    // Stray body flit in IDLE followed by a well-formed head flit south
    applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 3'd4, 3'd4), 5'b00000, 1'b0, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 3'd1, 3'd2), 5'b00000, 1'b1, 5'h1f);
    repeat (3) applyStimulus(1'b0, '0, 5'b00000, 1'b1, 5'h1f);

    // Asynchronous reset while a packet is active with two flits buffered
    applyStimulus(1'b1, mkFlit(1'b1, 1'b0, 3'd1, 3'd0), 5'b00000, 1'b1, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 3'd1, 3'd0), 5'b00000, 1'b1, 5'h1f);
    applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 3'd1, 3'd0), 5'b00000, 1'b0, 5'h1f);
    @(negedge clk);
    monEn = 1'b0;
    ifc.data_in_valid = 1'b0;
    ifc.grant = 5'b00001;
    ifc.out_ready = 5'h1f;
    #1;
    compare("pre-reset request", 64'(ifc.request), 64'(5'b00001));
    compare("pre-reset data_out_valid", 64'(ifc.data_out_valid), 64'(5'b00001));
    compare("pre-reset data_in_ready", 64'(ifc.data_in_ready), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    compare("async reset request", 64'(ifc.request), 64'(0));
    compare("async reset data_out_valid", 64'(ifc.data_out_valid), 64'(0));
    compare("async reset data_in_ready", 64'(ifc.data_in_ready), 64'(0));
    sb.delete();
    inPkt = 1'b0; inRoute = 5'b00000; outPkt = 1'b0; outRoute = 5'b00000;
    ifc.grant = 5'b00000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    monEn = 1'b1;
    #1;
    compare("post-reset data_in_ready", 64'(ifc.data_in_ready), 64'(1));
    compare("post-reset request", 64'(ifc.request), 64'(0));
    applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 3'd0, 3'd1), 5'b00000, 1'b1, 5'h1f);
    repeat (3) applyStimulus(1'b0, '0, 5'b00000, 1'b1, 5'h1f);

    // Randomised traffic with a mix of well-formed and malformed streams
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom % 10);
      follow = (r < 6);
      g = (r < 8) ? 5'($urandom) : 5'b00000;
      for (int k = 0; k < 5; k++) ordy[k] = (($urandom % 100) < 80);
      applyStimulus(($urandom % 4) != 0,
                    mkFlit(($urandom % 100) < 35, ($urandom % 100) < 35,
                           3'($urandom), 3'($urandom)),
                    g, follow, ordy);
    end

    repeat (40) applyStimulus(1'b0, '0, 5'b00000, 1'b1, 5'h1f);
    compare("scoreboard drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
